ping_pong_loader: RTL

Write-side controller for `ping_pong_ram`. It accepts a valid/ready stream of WIDTH-bit words and fills the write bank at consecutive addresses. It pulses `switch` to hand a completed bank to the consumer, and blocks further input while the consumer still owns the read bank. It sits directly upstream of every ping-pong buffer in the training datapath, between the DDR read engine and the PE-array buffers.

---
 rtl/global_param_pkg.sv | 18 +
 rtl/ping_pong_loader.sv | 117 +++++++++++
 2 files changed

// File: rtl/global_param_pkg.sv
// Shared definitions for the ping-pong loader: FSM state type and bit-width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package GLOBAL_PARAM;

  // Loader FSM: fill the write bank, wait for the read bank to be released, swap banks.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    SWAP = 2'd2
  } pp_ld_state_t;

  // Bits needed to address n entries (at least 1).
  function automatic int bw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ping_pong_loader.sv
// Write-side controller for ping_pong_ram: fills the write bank from a valid/ready stream, pulses pp_switch per full bank.
// Latency: accept at t -> pp_wr_en at t+1; last word at t -> WAIT t+1, pp_switch t+2 earliest, s_ready/rd_buf_valid t+3.
// Backpressure: s_ready drops from the last accepted word until the swap; the swap waits while the consumer owns the read bank.
//
// Ports: clk, rst (async active-low); cfg_len (words per fill, 0 or >DEPTH means DEPTH);
//   s_valid/s_ready/s_data input stream; pp_wr_addr/pp_wr_data/pp_wr_en/pp_switch to the RAM;
//   rd_buf_valid/rd_len describe the read bank, rd_done releases it.
// Option PP_LOADER_FLUSH_EN: adds input flush, which ends a non-empty fill early.
module ping_pong_loader
  import GLOBAL_PARAM::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = bw(DEPTH),
  parameter int WIDTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   cfg_len,
`ifdef PP_LOADER_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              s_valid,
  input  logic [WIDTH-1:0]  s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] pp_wr_addr,
  output logic [WIDTH-1:0]  pp_wr_data,
  output logic              pp_wr_en,
  output logic              pp_switch,
  output logic              rd_buf_valid,
  output logic [ADDR_W:0]   rd_len,
  input  logic              rd_done
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] v);
    if (v == '0 || v > DEPTH_L) return DEPTH_L;
    return v;
  endfunction

  pp_ld_state_t      state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W:0]   len;       // length of the fill in progress
  logic [ADDR_W:0]   fill_len;  // words actually written by the completed fill
  logic              rd_busy;
  logic              hs, last_word, flush_end, fill_end;

  // s_ready is a register that tracks "next state is FILL", so it is 0 in reset
  // and therefore a handshake implies the FSM is in FILL.
  assign hs        = s_valid & s_ready;
  assign last_word = hs && ({1'b0, cnt} == (len - ONE_L));

`ifdef PP_LOADER_FLUSH_EN
  assign flush_end = flush && (state == FILL) && ((cnt != '0) || hs);
`else
  assign flush_end = 1'b0;
`endif

  assign fill_end     = last_word | flush_end;
  assign pp_switch    = (state == SWAP);
  assign rd_buf_valid = rd_busy;

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (fill_end) state_nxt = WAIT;
      WAIT:    if (!rd_busy || rd_done) state_nxt = SWAP;
      SWAP:    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      cnt        <= '0;
      len        <= DEPTH_L;
      fill_len   <= '0;
      rd_busy    <= 1'b0;
      rd_len     <= '0;
      s_ready    <= 1'b0;
      pp_wr_en   <= 1'b0;
      pp_wr_addr <= '0;
      pp_wr_data <= '0;
    end else begin
      state    <= state_nxt;
      s_ready  <= (state_nxt == FILL);
      pp_wr_en <= hs;
      if (hs) begin
        pp_wr_addr <= cnt;
        pp_wr_data <= s_data;
      end

      if (fill_end) begin
        cnt      <= '0;
        fill_len <= {1'b0, cnt} + (hs ? ONE_L : '0);
      end else if (hs) begin
        cnt <= cnt + 1'b1;
      end

      // FILL with s_ready low only happens in the first cycle after reset.
      if ((state == FILL && !s_ready) || state == SWAP)
        len <= clamp_len(cfg_len);

      // In WAIT a release hands the bank straight to the swap that follows,
      // so rd_busy is held rather than dropping for one cycle.
      if (state == SWAP) begin
        rd_busy <= 1'b1;
        rd_len  <= fill_len;
      end else if (rd_done && state != WAIT) begin
        rd_busy <= 1'b0;
      end
    end
  end

endmodule
